// File: rtl/axil_decerr_slave_wr.sv
// AXI-Lite write-channel default slave: accepts AW and W in either order, discards the data and
// answers DECERR. Also exposes a saturating error counter and the last offending address.
module axil_decerr_slave_wr #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter logic [1:0]  RESP_CODE      = 2'b11
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  output logic [CNT_WIDTH-1:0]        err_count,
  output logic [AXI_ADDR_WIDTH-1:0]   err_addr,
  output logic                        err_pulse,
  input  logic                        err_clear
);

  typedef enum logic [1:0] {StIdle, StGotAw, StGotW, StResp} state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        err_count_q;
  logic [AXI_ADDR_WIDTH-1:0]   err_addr_q;
  logic                        err_pulse_q;
  logic                        aw_hs, w_hs, b_hs, enter_resp;

  // Write data and strobes are deliberately discarded.
  logic unused_wdata;
  assign unused_wdata = ^{s_axil_wdata, s_axil_wstrb};

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign b_hs  = s_axil_bvalid & s_axil_bready;

  // Readies are decoded from state only, so no valid-to-ready combinational path exists.
  always_comb begin
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_axil_awready = 1'b1;
        s_axil_wready  = 1'b1;
      end
      StGotAw: s_axil_wready  = 1'b1;
      StGotW:  s_axil_awready = 1'b1;
      StResp:  s_axil_bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs && w_hs)  state_d = StResp;
        else if (aw_hs)     state_d = StGotAw;
        else if (w_hs)      state_d = StGotW;
      end
      StGotAw: if (w_hs)  state_d = StResp;
      StGotW:  if (aw_hs) state_d = StResp;
      StResp:  if (b_hs)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_q != StResp) && (state_d == StResp);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      err_count_q <= '0;
      err_addr_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_pulse_q <= enter_resp;
      if (aw_hs) err_addr_q <= s_axil_awaddr;
      // Clear takes priority over a coincident increment.
      if (err_clear) begin
        err_count_q <= '0;
      end else if (enter_resp && (err_count_q != {CNT_WIDTH{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign s_axil_bresp = RESP_CODE;
  assign err_count    = err_count_q;
  assign err_addr     = err_addr_q;
  assign err_pulse    = err_pulse_q;

endmodule
